// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue
// Brief    : Byte FIFO in front of a UART transmitter. An IDLE/ISSUE/BUSY/DRAIN
//            FSM hands one byte at a time to the transmitter using tx_done.
//            Define UART_TX_QUEUE_CTS_EN to add cts_n flow control on issue.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_queue #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic                     tx_valid,
    output logic [7:0]               tx_data,
    input  logic                     tx_done
`ifdef UART_TX_QUEUE_CTS_EN
    ,
    input  logic                     cts_n
`endif
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_tw = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    localparam logic [c_aw:0]   c_full_lvl  = (c_aw + 1)'(DEPTH);
    localparam logic [c_tw-1:0] c_busy_last = c_tw'(BUSY_TIMEOUT - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_busy  = 2'd2;
    localparam logic [1:0] c_st_drain = 2'd3;

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_level;
    logic            r_ovf;
    logic            r_tx_valid;
    logic [7:0]      r_tx_data;
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [c_tw-1:0] r_busy_cnt;
    logic [c_tw-1:0] w_busy_cnt_nxt;
    logic            w_push;
    logic            w_pop;
    logic            w_ovf_set;
    logic            w_load_tx;
    logic            w_cts_ok;

`ifdef UART_TX_QUEUE_CTS_EN
    assign w_cts_ok = ~cts_n;
`else
    assign w_cts_ok = 1'b1;
`endif

    assign full      = (r_level == c_full_lvl);
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign ovf       = r_ovf;
    assign tx_valid  = r_tx_valid;
    assign tx_data   = r_tx_data;

    // Full is judged on pre-edge state, so a write alongside a pop while full is still dropped.
    assign w_push    = wr_en & ~full;
    assign w_ovf_set = wr_en & full;

    // ------------------------------------------------------------------------
    // Issue FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Issue FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (!empty && tx_done && w_cts_ok) begin
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue: begin
                w_state_nxt = c_st_busy;
            end
            c_st_busy: begin
                if (!tx_done || (r_busy_cnt == c_busy_last)) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                if (tx_done) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Issue FSM: outputs (registered below so tx_valid coincides with ISSUE)
    // ------------------------------------------------------------------------
    always_comb begin
        w_pop          = 1'b0;
        w_load_tx      = 1'b0;
        w_busy_cnt_nxt = '0;
        if (r_state == c_st_issue) begin
            w_pop = 1'b1;
        end
        if ((r_state != c_st_issue) && (w_state_nxt == c_st_issue)) begin
            w_load_tx = 1'b1;
        end
        if (r_state == c_st_busy) begin
            w_busy_cnt_nxt = r_busy_cnt + c_tw'(1);
        end
    end

    // ------------------------------------------------------------------------
    // FIFO bookkeeping, overflow flag and transmitter-side registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_ovf      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (c_aw + 1)'(1);
                2'b01:   r_level <= r_level - (c_aw + 1)'(1);
                default: r_level <= r_level;
            endcase
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
            r_tx_valid <= w_load_tx;
            if (w_load_tx) begin
                r_tx_data <= r_mem[r_rd_ptr];
            end
            r_busy_cnt <= w_busy_cnt_nxt;
        end
    end

    // Storage is not reset; pointers and level alone define what is valid.
    always_ff @(posedge clk) begin
        if (rst && w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_queue
// Brief    : Scoreboard bench for uart_tx_queue with a simple transmitter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_queue;

    localparam int DEPTH        = 16;
    localparam int BUSY_TIMEOUT = 4;
    localparam int CLK_DIV      = 4;
    localparam int FRAME        = CLK_DIV * 10;

    logic       clk         = 1'b0;
    logic       rst         = 1'b0;
    logic       wr_en       = 1'b0;
    logic [7:0] wr_data     = 8'h00;
    logic       ovf_clr     = 1'b0;
    logic       tx_done_man = 1'b1;
    logic       model_en    = 1'b0;
    logic       model_busy  = 1'b0;
    int         model_cnt   = 0;

    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       ovf;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_done;
`ifdef UART_TX_QUEUE_CTS_EN
    logic       cts_n = 1'b0;
`endif

    int         checks_total = 0;
    int         checks_pass  = 0;
    int         rx_count     = 0;
    logic [7:0] exp_q [$];

    assign tx_done = model_en ? ~model_busy : tx_done_man;

    uart_tx_queue #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_done  (tx_done)
`ifdef UART_TX_QUEUE_CTS_EN
        ,
        .cts_n    (cts_n)
`endif
    );

    always #5 clk = ~clk;

    // Transmitter: accepts a byte on tx_valid, then stays busy for one frame.
    always @(posedge clk) begin
        if (!model_en) begin
            model_busy <= 1'b0;
            model_cnt  <= 0;
        end else if (!model_busy) begin
            if (tx_valid) begin
                model_busy <= 1'b1;
                model_cnt  <= FRAME - 1;
            end
        end else if (model_cnt == 0) begin
            model_busy <= 1'b0;
        end else begin
            model_cnt <= model_cnt - 1;
        end
    end

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (tx_valid) begin
                rx_count++;
                checks_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL tx_unexpected: got tx_data=%02h, want no issue", tx_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data !== e)
                        $display("FAIL tx_order: got %02h want %02h", tx_data, e);
                    else
                        checks_pass++;
                end
            end
        end
    endtask

    task automatic wait_drained(input int budget, input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (level == 5'd0 && exp_q.size() == 0 && tx_done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (8) @(negedge clk);
        checks_total++;
        if (!ok)
            $display("FAIL %s_drain: level=%0d pending=%0d, want level 0 and none pending within %0d cycles",
                     tag, level, exp_q.size(), budget);
        else
            checks_pass++;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h3C;
        repeat (3) @(negedge clk);
        checks_total++; if (level !== 5'd0)    $display("FAIL reset_level: got %0d want 0", level); else checks_pass++;
        checks_total++; if (empty !== 1'b1)    $display("FAIL reset_empty: got %b want 1", empty); else checks_pass++;
        checks_total++; if (full !== 1'b0)     $display("FAIL reset_full: got %b want 0", full); else checks_pass++;
        checks_total++; if (ovf !== 1'b0)      $display("FAIL reset_ovf: got %b want 0", ovf); else checks_pass++;
        checks_total++; if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b want 0", tx_valid); else checks_pass++;
        checks_total++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %02h want 00", tx_data); else checks_pass++;
        rst   = 1'b1;
        wr_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_byte();
        tx_done_man = 1'b1;
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        checks_total++; if (level !== 5'd1)    $display("FAIL single_level_write: got %0d want 1", level); else checks_pass++;
        checks_total++; if (tx_valid !== 1'b0) $display("FAIL single_no_bypass: got %b want 0", tx_valid); else checks_pass++;
        @(negedge clk);
        checks_total++; if (tx_valid !== 1'b1) $display("FAIL single_tx_valid: got %b want 1", tx_valid); else checks_pass++;
        checks_total++; if (tx_data !== 8'hA5) $display("FAIL single_tx_data: got %02h want a5", tx_data); else checks_pass++;
        @(negedge clk);
        checks_total++; if (tx_valid !== 1'b0) $display("FAIL single_pulse_width: got %b want 0", tx_valid); else checks_pass++;
        checks_total++; if (level !== 5'd0)    $display("FAIL single_level_pop: got %0d want 0", level); else checks_pass++;
        wait_drained(50, "single");
    endtask

    task automatic test_overflow();
        tx_done_man = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i == 16) begin
                checks_total++; if (full !== 1'b1)   $display("FAIL ovf_full: got %b want 1", full); else checks_pass++;
                checks_total++; if (level !== 5'd16) $display("FAIL ovf_level16: got %0d want 16", level); else checks_pass++;
                checks_total++; if (ovf !== 1'b0)    $display("FAIL ovf_early: got %b want 0", ovf); else checks_pass++;
            end
            wr_en   = 1'b1;
            wr_data = 8'(i);
            if (i < 16) exp_q.push_back(8'(i));
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks_total++; if (ovf !== 1'b1)    $display("FAIL ovf_set: got %b want 1", ovf); else checks_pass++;
        checks_total++; if (level !== 5'd16) $display("FAIL ovf_dropped: got %0d want 16", level); else checks_pass++;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        checks_total++; if (ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", ovf); else checks_pass++;
        wr_en = 1'b1; wr_data = 8'hEE; ovf_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; ovf_clr = 1'b0;
        checks_total++; if (ovf !== 1'b1)    $display("FAIL ovf_set_wins: got %b want 1", ovf); else checks_pass++;
        checks_total++; if (level !== 5'd16) $display("FAIL ovf_level_hold: got %0d want 16", level); else checks_pass++;
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr     = 1'b0;
        tx_done_man = 1'b1;
        wait_drained(400, "overflow");
    endtask

    task automatic test_wrap();
        int rx_start;
        rx_start = rx_count;
        model_en = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                wr_en   = 1'b1;
                wr_data = 8'($urandom());
                exp_q.push_back(wr_data);
            end
            @(negedge clk);
            wr_en = 1'b0;
            wait_drained(1000, "wrap");
        end
        checks_total++; if (rx_count - rx_start != 30) $display("FAIL wrap_count: got %0d want 30", rx_count - rx_start); else checks_pass++;
        checks_total++; if (level !== 5'd0) $display("FAIL wrap_level: got %0d want 0", level); else checks_pass++;
        model_en    = 1'b0;
        tx_done_man = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        tx_done_man = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'h20 + 8'(k);
            exp_q.push_back(wr_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks_total++; if (level !== 5'd5) $display("FAIL b2b_level_pre: got %0d want 5", level); else checks_pass++;
        tx_done_man = 1'b1;
        @(negedge clk);
        checks_total++; if (tx_valid !== 1'b1) $display("FAIL b2b_issue: got %b want 1", tx_valid); else checks_pass++;
        wr_en = 1'b1; wr_data = 8'h55; exp_q.push_back(8'h55);
        tx_done_man = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        checks_total++; if (level !== 5'd5) $display("FAIL b2b_level_post: got %0d want 5", level); else checks_pass++;
        tx_done_man = 1'b1;
        wait_drained(200, "b2b");
    endtask

    task automatic test_timeout();
        int pulses[$];
        tx_done_man = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (tx_valid) pulses.push_back(c);
            if (c < 3) begin
                wr_en   = 1'b1;
                wr_data = 8'h71 + 8'(c);
                exp_q.push_back(wr_data);
            end else begin
                wr_en = 1'b0;
            end
        end
        checks_total++;
        if (pulses.size() != 3) begin
            $display("FAIL timeout_pulses: got %0d want 3", pulses.size());
        end else begin
            checks_pass++;
            checks_total++; if (pulses[0] != 2)             $display("FAIL timeout_first: got cycle %0d want 2", pulses[0]); else checks_pass++;
            checks_total++; if (pulses[1] - pulses[0] != 7) $display("FAIL timeout_gap1: got %0d want 7", pulses[1] - pulses[0]); else checks_pass++;
            checks_total++; if (pulses[2] - pulses[1] != 7) $display("FAIL timeout_gap2: got %0d want 7", pulses[2] - pulses[1]); else checks_pass++;
        end
        wait_drained(50, "timeout");
    endtask

    task automatic test_reset_in_issue();
        int stray;
        stray = 0;
        tx_done_man = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_data = 8'h80 + 8'(k);
            if (k == 0) exp_q.push_back(wr_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
        checks_total++; if (ovf !== 1'b1) $display("FAIL rii_ovf_pre: got %b want 1", ovf); else checks_pass++;
        tx_done_man = 1'b1;
        @(negedge clk);
        checks_total++; if (tx_valid !== 1'b1) $display("FAIL rii_issue: got %b want 1", tx_valid); else checks_pass++;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks_total++; if (tx_valid !== 1'b0) $display("FAIL rii_tx_valid: got %b want 0", tx_valid); else checks_pass++;
        checks_total++; if (level !== 5'd0)    $display("FAIL rii_level: got %0d want 0", level); else checks_pass++;
        checks_total++; if (empty !== 1'b1)    $display("FAIL rii_empty: got %b want 1", empty); else checks_pass++;
        checks_total++; if (ovf !== 1'b0)      $display("FAIL rii_ovf: got %b want 0", ovf); else checks_pass++;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (tx_valid) stray++;
        end
        checks_total++; if (stray != 0) $display("FAIL rii_no_issue: got %0d pulses want 0", stray); else checks_pass++;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single_byte();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_timeout();
        test_reset_in_issue();
        checks_total++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d bytes want 0", exp_q.size()); else checks_pass++;
        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", checks_pass, checks_total);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
